mips_debug_loader: RTL and testbench

//   Upstream control stage of top_mips. Takes a byte stream from the UART receiver,

---
 rtl/mips_debug_loader_if.sv | 27 ++
 rtl/mips_debug_loader.sv | 135 +++++++++++++
 tb/tb_mips_debug_loader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_debug_loader_if.sv
// Bus between the UART-fed debug loader and the instruction memory / top_mips control pins.
// master = loader side, slave = environment side.
interface mips_debug_loader_if #(
    parameter int LEN      = 32,
    parameter int ADDR_LEN = 10
);
    logic [7:0]          rx_data;
    logic                rx_done;
    logic                halt;
    logic                imem_we;
    logic [ADDR_LEN-1:0] imem_addr;
    logic [LEN-1:0]      imem_data;
    logic                cpu_enable;
    logic                cpu_reset;
    logic                load_done;
    logic                busy;

    modport master (
        input  rx_data, rx_done, halt,
        output imem_we, imem_addr, imem_data, cpu_enable, cpu_reset, load_done, busy
    );

    modport slave (
        output rx_data, rx_done, halt,
        input  imem_we, imem_addr, imem_data, cpu_enable, cpu_reset, load_done, busy
    );
endinterface

// File: rtl/mips_debug_loader.sv
// Debug loader: decodes UART command bytes, writes instruction words into imem,
// and drives top_mips enable/reset for continuous RUN or single STEP.
module mips_debug_loader #(
    parameter int LEN      = 32,
    parameter int ADDR_LEN = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_debug_loader_if.master  bus
);
    localparam int NBYTES = LEN / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        GET_COUNT,
        GET_BYTES,
        RUN,
        STEP
    } state_t;

    state_t              state;
    logic [BCW-1:0]      byte_cnt;
    logic [7:0]          word_cnt;
    logic [7:0]          word_total;
    logic [LEN-1:0]      shreg;
    logic [LEN-1:0]      word_next;
    logic                imem_we;
    logic [ADDR_LEN-1:0] imem_addr;
    logic [LEN-1:0]      imem_data;
    logic                cpu_enable;
    logic                cpu_reset;
    logic                load_done;

    assign word_next = (shreg << 8) | LEN'(bus.rx_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            word_total <= '0;
            shreg      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_data  <= '0;
            cpu_enable <= 1'b0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            load_done <= 1'b0;
            // Address advances in the cycle after each write pulse.
            if (imem_we)
                imem_addr <= imem_addr + ADDR_LEN'(1);

            case (state)
                IDLE: begin
                    cpu_enable <= 1'b0;
                    cpu_reset  <= 1'b0;
                    if (bus.rx_done) begin
                        case (bus.rx_data)
                            8'h01: begin
                                state     <= GET_COUNT;
                                cpu_reset <= 1'b1;
                            end
                            8'h02:   state <= RUN;
                            8'h03:   state <= STEP;
                            default: state <= IDLE;
                        endcase
                    end
                end

                GET_COUNT: begin
                    if (bus.rx_done) begin
                        imem_addr <= '0;
                        byte_cnt  <= '0;
                        word_cnt  <= '0;
                        shreg     <= '0;
                        if (bus.rx_data == 8'h00) begin
                            state     <= IDLE;
                            load_done <= 1'b1;
                        end else begin
                            word_total <= bus.rx_data;
                            state      <= GET_BYTES;
                        end
                    end
                end

                GET_BYTES: begin
                    if (bus.rx_done) begin
                        if (byte_cnt == BCW'(NBYTES - 1)) begin
                            imem_data <= word_next;
                            imem_we   <= 1'b1;
                            byte_cnt  <= '0;
                            shreg     <= '0;
                            word_cnt  <= word_cnt + 8'd1;
                            if (word_cnt + 8'd1 == word_total) begin
                                state     <= IDLE;
                                load_done <= 1'b1;
                            end
                        end else begin
                            shreg    <= word_next;
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end

                RUN: begin
                    if (bus.halt) begin
                        cpu_enable <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cpu_enable <= 1'b1;
                    end
                end

                STEP: begin
                    cpu_enable <= ~bus.halt;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.imem_we    = imem_we;
    assign bus.imem_addr  = imem_addr;
    assign bus.imem_data  = imem_data;
    assign bus.cpu_enable = cpu_enable;
    assign bus.cpu_reset  = cpu_reset;
    assign bus.load_done  = load_done;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mips_debug_loader.sv
// Bench for mips_debug_loader: two instances (ADDR_LEN 10 and 2) share one byte stream;
// a write scoreboard plus pulse counters check against command-level expectations.
module tb_mips_debug_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_debug_loader_if #(.LEN(32), .ADDR_LEN(10)) bus1 ();
    mips_debug_loader_if #(.LEN(32), .ADDR_LEN(2))  bus2 ();

    mips_debug_loader #(.LEN(32), .ADDR_LEN(10)) u_dut (
        .clk(clk), .reset(reset), .bus(bus1.master)
    );
    mips_debug_loader #(.LEN(32), .ADDR_LEN(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.master)
    );

    assign bus2.rx_data = bus1.rx_data;
    assign bus2.rx_done = bus1.rx_done;
    assign bus2.halt    = bus1.halt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } wr_t;
    wr_t         expq[$];
    logic [31:0] wq[$];

    int   n_ld   = 0;
    int   n_en   = 0;
    int   n_rise = 0;
    logic prev_en = 1'b0;
    logic prev_we = 1'b0;
    bit   in_load = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the next expected word; count pulses.
    always @(negedge clk) begin
        wr_t w;
        if (bus1.imem_we || bus2.imem_we) begin
            check("we_pair", bus2.imem_we, bus1.imem_we);
            check("we_width", prev_we, 1'b0);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         bus1.imem_addr, bus1.imem_data);
            end else begin
                w = expq.pop_front();
                check("addr", bus1.imem_addr, w.idx % 1024);
                check("addr2", bus2.imem_addr, w.idx % 4);
                check("data", bus1.imem_data, w.data);
                check("data2", bus2.imem_data, w.data);
            end
        end
        if (in_load) check("cpu_reset_in_load", bus1.cpu_reset, 1'b1);
        if (bus1.load_done) begin
            n_ld++;
            in_load = 1'b0;
        end
        if (bus1.cpu_enable) n_en++;
        if (bus1.cpu_enable && !prev_en) n_rise++;
        prev_en = bus1.cpu_enable;
        prev_we = bus1.imem_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus1.rx_data = b;
        bus1.rx_done = 1'b1;
        tick();
        bus1.rx_done = 1'b0;
        bus1.rx_data = 8'($urandom);
        repeat (gap) tick();
    endtask

    // Loads the words in wq; the last byte is sent with no gap so the final write is visible.
    task automatic do_load(input int maxgap);
        int ld0;
        int n;
        logic [31:0] w;
        ld0 = n_ld;
        n   = wq.size();
        send(8'h01, $urandom_range(0, maxgap));
        in_load = 1'b1;
        send(8'(n), $urandom_range(0, maxgap));
        for (int k = 0; k < n; k++) begin
            w = wq[k];
            expq.push_back('{idx: k, data: w});
            for (int b = 3; b >= 0; b--)
                send(w[8*b +: 8], (k == n - 1 && b == 0) ? 0 : $urandom_range(0, maxgap));
        end
        check("last_we", bus1.imem_we, 1'b1);
        check("last_load_done", bus1.load_done, 1'b1);
        check("reset_at_done", bus1.cpu_reset, 1'b1);
        tick();
        check("we_drop", bus1.imem_we, 1'b0);
        check("load_done_drop", bus1.load_done, 1'b0);
        check("cpu_reset_drop", bus1.cpu_reset, 1'b0);
        check("busy_after_load", bus1.busy, 1'b0);
        check("addr_after_load", bus1.imem_addr, n % 1024);
        repeat (2) tick();
        check("load_done_count", n_ld - ld0, 1);
        check("queue_drained", expq.size(), 0);
    endtask

    task automatic do_run(input int d);
        int en0;
        int r0;
        en0 = n_en;
        r0  = n_rise;
        bus1.halt = 1'b0;
        send(8'h02, 0);
        repeat (d) tick();
        bus1.halt = 1'b1;
        repeat (3) tick();
        check("run_en_cycles", n_en - en0, d);
        check("run_en_rises", n_rise - r0, (d > 0) ? 1 : 0);
        check("run_busy_after", bus1.busy, 1'b0);
        bus1.halt = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, bus1.imem_we, 1'b0);
        check({tag, "_addr"}, bus1.imem_addr, 0);
        check({tag, "_addr2"}, bus2.imem_addr, 0);
        check({tag, "_data"}, bus1.imem_data, 0);
        check({tag, "_en"}, bus1.cpu_enable, 1'b0);
        check({tag, "_rst"}, bus1.cpu_reset, 1'b1);
        check({tag, "_ld"}, bus1.load_done, 1'b0);
        check({tag, "_busy"}, bus1.busy, 1'b0);
    endtask

    task automatic release_reset();
        check("rst_before_release", bus1.cpu_reset, 1'b1);
        reset = 1'b0;
        tick();
        check("rst_first_clock", bus1.cpu_reset, 1'b0);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       hlt;
        logic       exp_busy;
        logic       exp_rst;
        int         exp_en;
        int         exp_ld;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int en0;
        int ld0;
        int r0;
        logic [7:0] b;

        tbl[0] = '{8'h7F, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{8'hFF, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[3] = '{8'h04, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[4] = '{8'h03, 1'b0, 1'b1, 1'b0, 1, 0};
        tbl[5] = '{8'h03, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[6] = '{8'h02, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[7] = '{8'h01, 1'b0, 1'b1, 1'b1, 0, 1};

        reset        = 1'b1;
        bus1.rx_data = 8'h00;
        bus1.rx_done = 1'b0;
        bus1.halt    = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        release_reset();

        // Single command bytes from IDLE
        for (int i = 0; i < 8; i++) begin
            bus1.halt = tbl[i].hlt;
            en0 = n_en;
            ld0 = n_ld;
            send(tbl[i].cmd, 0);
            check($sformatf("tbl%0d_busy", i), bus1.busy, tbl[i].exp_busy);
            check($sformatf("tbl%0d_rst", i), bus1.cpu_reset, tbl[i].exp_rst);
            if (tbl[i].cmd == 8'h01) send(8'h00, 0);
            repeat (4) tick();
            check($sformatf("tbl%0d_en", i), n_en - en0, tbl[i].exp_en);
            check($sformatf("tbl%0d_ld", i), n_ld - ld0, tbl[i].exp_ld);
            check($sformatf("tbl%0d_idle", i), bus1.busy, 1'b0);
            bus1.halt = 1'b0;
            tick();
        end

        // Two-word load with the reference words
        wq = {32'h2001_0005, 32'h0000_0000};
        do_load(0);

        // RUN with halt after 20 enabled cycles
        en0 = n_en;
        send(8'h02, 0);
        check("run_entry_en", bus1.cpu_enable, 1'b0);
        tick();
        check("run_en_high", bus1.cpu_enable, 1'b1);
        repeat (19) tick();
        bus1.halt = 1'b1;
        tick();
        check("run_halt_en", bus1.cpu_enable, 1'b0);
        repeat (2) tick();
        check("run20_cycles", n_en - en0, 20);
        check("run20_busy", bus1.busy, 1'b0);
        bus1.halt = 1'b0;

        // Three STEPs, then three with halt held
        en0 = n_en;
        r0  = n_rise;
        for (int i = 0; i < 3; i++) send(8'h03, 1);
        repeat (3) tick();
        check("step3_rises", n_rise - r0, 3);
        check("step3_cycles", n_en - en0, 3);
        bus1.halt = 1'b1;
        en0 = n_en;
        for (int i = 0; i < 3; i++) send(8'h03, 1);
        repeat (3) tick();
        check("step_halt_cycles", n_en - en0, 0);
        bus1.halt = 1'b0;

        // Five words: ADDR_LEN=2 instance wraps to 0
        wq.delete();
        for (int k = 0; k < 5; k++) wq.push_back($urandom);
        do_load(1);

        // Reset after two bytes of a word
        send(8'h01, 0);
        in_load = 1'b1;
        send(8'h01, 0);
        send(8'hAB, 0);
        send(8'hCD, 1);
        #2;
        reset   = 1'b1;
        in_load = 1'b0;
        #1;
        check_reset_values("midload");
        repeat (2) tick();
        release_reset();
        wq = {32'hDEAD_BEEF};
        do_load(0);

        // Reset in the middle of RUN
        send(8'h02, 0);
        repeat (5) tick();
        check("midrun_en", bus1.cpu_enable, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("midrun_en_reset", bus1.cpu_enable, 1'b0);
        check("midrun_busy_reset", bus1.busy, 1'b0);
        check("midrun_rst_reset", bus1.cpu_reset, 1'b1);
        repeat (2) tick();
        release_reset();

        // Random command mix
        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    wq.delete();
                    for (int k = 0; k < int'($urandom_range(1, 6)); k++) wq.push_back($urandom);
                    do_load(2);
                end
                1: begin
                    bus1.halt = 1'($urandom);
                    en0 = n_en;
                    send(8'h03, 0);
                    repeat (3) tick();
                    check("rnd_step", n_en - en0, bus1.halt ? 0 : 1);
                    bus1.halt = 1'b0;
                end
                2: do_run($urandom_range(0, 15));
                default: begin
                    b = 8'($urandom);
                    if (b >= 8'h01 && b <= 8'h03) b = b + 8'h10;
                    en0 = n_en;
                    send(b, 0);
                    check("rnd_junk_busy", bus1.busy, 1'b0);
                    repeat (2) tick();
                    check("rnd_junk_en", n_en - en0, 0);
                end
            endcase
            tick();
        end

        repeat (3) tick();
        check("final_queue", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
